// File: rtl/irq_pkg.sv
// irq_pkg: shared types and constants for the interrupt sequencer.
//   irq_state_e   - sequencer FSM states (IDLE, REQ, SERVICE)
//   IRQ_W, VEC_W  - mask/source bus width and vector width
//   VBASE_DEF, VSTRIDE_DEF - default vector placement (one JMP slot per source)
//   irq_vec_calc  - vector address for a source index, modulo 2**VEC_W
package irq_pkg;

    localparam int IRQ_W = 8;
    localparam int VEC_W = 8;

    localparam logic [VEC_W-1:0] VBASE_DEF   = 8'd2;
    localparam logic [VEC_W-1:0] VSTRIDE_DEF = 8'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    function automatic logic [VEC_W-1:0] irq_vec_calc(
        input logic [VEC_W-1:0] base,
        input logic [VEC_W-1:0] stride,
        input logic [2:0]       idx
    );
        logic [VEC_W-1:0] offs;
        // Truncation to VEC_W bits gives the intended wrap-around.
        offs = stride * {{(VEC_W-3){1'b0}}, idx};
        return base + offs;
    endfunction

endpackage

// File: rtl/irq_sequencer_if.sv
// irq_sequencer_if: CPU <-> interrupt sequencer bus.
//   irq_req / irq_vec       - request and vector from the sequencer
//   irq_ack / eoi           - accept vector / end of service routine
//   ei / di                 - global enable / disable pulses
//   mask_we / mask_wdata    - mask register write port
// master = CPU side, slave = sequencer side.
interface irq_sequencer_if;
    import irq_pkg::*;

    logic             irq_req;
    logic [VEC_W-1:0] irq_vec;
    logic             irq_ack;
    logic             eoi;
    logic             ei;
    logic             di;
    logic             mask_we;
    logic [IRQ_W-1:0] mask_wdata;

    modport master (
        input  irq_req, irq_vec,
        output irq_ack, eoi, ei, di, mask_we, mask_wdata
    );

    modport slave (
        output irq_req, irq_vec,
        input  irq_ack, eoi, ei, di, mask_we, mask_wdata
    );

endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational priority encoder, highest set index wins.
//   req - request vector (N_SRC bits)
//   idx - index of the highest set bit (0 when none set)
//   any - at least one bit of req is set
module irq_prio_enc #(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] req,
    output logic [2:0]       idx,
    output logic             any
);

    // Ascending scan: later (higher) hits overwrite earlier ones.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (req[i]) begin
                idx = 3'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// irq_sequencer: synchronises and edge-detects up to 8 interrupt sources,
// keeps them pending under a CPU mask, and hands one vector at a time to the
// CPU fetch unit over a req/ack handshake. No nesting: a new request waits
// for end-of-interrupt.
//   clock, rst   - step clock, asynchronous active-low reset
//   src          - raw asynchronous sources, active-high
//   bus          - CPU bus (req/vec out; ack, eoi, ei, di, mask write in)
//   pending      - pending register
//   mask         - current mask (1 = enabled)
//   ie           - global interrupt enable
//   in_service   - handler active
//
// state   | meaning
// IDLE    | waiting for ie and an unmasked pending source
// REQ     | irq_req up with a latched vector, waiting for irq_ack
// SERVICE | handler running, waiting for eoi
module irq_sequencer
    import irq_pkg::*;
#(
    parameter int               N_SRC    = 8,
    parameter logic [VEC_W-1:0] VBASE    = VBASE_DEF,
    parameter logic [VEC_W-1:0] VSTRIDE  = VSTRIDE_DEF,
    parameter logic [IRQ_W-1:0] MASK_RST = 8'hFF
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [N_SRC-1:0]  src,
    irq_sequencer_if.slave    bus,
    output logic [N_SRC-1:0]  pending,
    output logic [IRQ_W-1:0]  mask,
    output logic              ie,
    output logic              in_service
);

    irq_state_e       state_q, state_d;
    logic [N_SRC-1:0] sync1_q, sync1_d;
    logic [N_SRC-1:0] sync2_q, sync2_d;
    logic [N_SRC-1:0] hist_q, hist_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [IRQ_W-1:0] mask_q, mask_d;
    logic             ie_q, ie_d;
    logic             in_service_q, in_service_d;
    logic [2:0]       idx_q, idx_d;
    logic             irq_req_q, irq_req_d;
    logic [VEC_W-1:0] irq_vec_q, irq_vec_d;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] armed;
    logic [2:0]       enc_idx;
    logic             enc_any;

    assign rise  = sync2_q & ~hist_q;
    assign armed = pending_q & mask_q[N_SRC-1:0];

    irq_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio_enc (
        .req (armed),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_comb begin
        sync1_d      = src;
        sync2_d      = sync1_q;
        hist_d       = sync2_q;
        state_d      = state_q;
        idx_d        = idx_q;
        irq_req_d    = irq_req_q;
        irq_vec_d    = irq_vec_q;
        in_service_d = in_service_q;
        clr          = '0;
        mask_d       = bus.mask_we ? bus.mask_wdata : mask_q;

        // di after ei so a simultaneous pair leaves ie cleared.
        ie_d = ie_q;
        if (bus.ei) ie_d = 1'b1;
        if (bus.di) ie_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ie_q && enc_any) begin
                    state_d   = REQ;
                    idx_d     = enc_idx;
                    irq_vec_d = irq_vec_calc(VBASE, VSTRIDE, enc_idx);
                    irq_req_d = 1'b1;
                end
            end
            REQ: begin
                // Ack takes precedence over a withdraw in the same cycle.
                if (bus.irq_ack) begin
                    for (int i = 0; i < N_SRC; i++) begin
                        clr[i] = (idx_q == 3'(i));
                    end
                    irq_req_d    = 1'b0;
                    ie_d         = 1'b0;
                    in_service_d = 1'b1;
                    state_d      = SERVICE;
                end else if (bus.di || !mask_q[idx_q]) begin
                    irq_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            SERVICE: begin
                if (bus.eoi) begin
                    in_service_d = 1'b0;
                    ie_d         = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                irq_req_d    = 1'b0;
                in_service_d = 1'b0;
                state_d      = IDLE;
            end
        endcase

        // A fresh edge on the granted source survives its own ack.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sync1_q      <= '0;
            sync2_q      <= '0;
            hist_q       <= '0;
            pending_q    <= '0;
            mask_q       <= MASK_RST;
            ie_q         <= 1'b1;
            in_service_q <= 1'b0;
            idx_q        <= '0;
            irq_req_q    <= 1'b0;
            irq_vec_q    <= '0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            hist_q       <= hist_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            ie_q         <= ie_d;
            in_service_q <= in_service_d;
            idx_q        <= idx_d;
            irq_req_q    <= irq_req_d;
            irq_vec_q    <= irq_vec_d;
        end
    end

    assign bus.irq_req = irq_req_q;
    assign bus.irq_vec = irq_vec_q;
    assign pending     = pending_q;
    assign mask        = mask_q;
    assign ie          = ie_q;
    assign in_service  = in_service_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: scoreboard bench. The stimulus thread acts as the CPU and
// keeps an abstract model (set of pending sources, mask); each time a request
// is due it queues the expected vector, and a monitor thread pops and compares
// whenever the DUT raises irq_req.
module tb_irq_sequencer;

    logic       clock = 1'b0;
    logic       rst   = 1'b0;
    logic [7:0] src   = 8'h00;
    logic [7:0] pending;
    logic [7:0] mask;
    logic       ie;
    logic       in_service;

    irq_sequencer_if bus ();

    irq_sequencer #(
        .N_SRC    (8),
        .VBASE    (8'd2),
        .VSTRIDE  (8'd2),
        .MASK_RST (8'hFF)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .src        (src),
        .bus        (bus),
        .pending    (pending),
        .mask       (mask),
        .ie         (ie),
        .in_service (in_service)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_pend = 8'h00;
    logic [7:0] m_mask = 8'hFF;

    // ---------------- reference helpers ----------------
    function automatic int top_idx(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] vec_of(input int i);
        return 8'((2 + 2 * i) % 256);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_next();
        exp_q.push_back(vec_of(top_idx(m_pend & m_mask)));
    endtask

    task automatic raise(input logic [7:0] pat);
        src = pat;
        @(negedge clock);
        src = 8'h00;
        m_pend = m_pend | pat;
    endtask

    task automatic write_mask(input logic [7:0] v);
        bus.mask_wdata = v;
        bus.mask_we    = 1'b1;
        @(negedge clock);
        bus.mask_we = 1'b0;
        m_mask = v;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.irq_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_req: irq_req stayed 0 for 40 cycles, expected 1");
        end
    endtask

    task automatic serve_one();
        bit ok;
        int idx;
        wait_req(ok);
        idx = top_idx(m_pend & m_mask);
        tick($urandom_range(0, 2));
        bus.irq_ack = 1'b1;
        @(negedge clock);
        bus.irq_ack = 1'b0;
        if (idx >= 0) m_pend[idx] = 1'b0;
        check("ack_pending", 32'(pending), 32'(m_pend));
        check("ack_ie", 32'(ie), 32'd0);
        check("ack_in_service", 32'(in_service), 32'd1);
        check("ack_irq_req", 32'(bus.irq_req), 32'd0);
        tick($urandom_range(0, 3));
        if ((m_pend & m_mask) != 8'h00) expect_next();
        bus.eoi = 1'b1;
        @(negedge clock);
        bus.eoi = 1'b0;
        check("eoi_in_service", 32'(in_service), 32'd0);
        check("eoi_ie", 32'(ie), 32'd1);
        if ((m_pend & m_mask) != 8'h00) begin
            @(negedge clock);
            check("b2b_irq_req", 32'(bus.irq_req), 32'd1);
        end
    endtask

    task automatic drain();
        while ((m_pend & m_mask) != 8'h00) serve_one();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_irq_req"}, 32'(bus.irq_req), 32'd0);
        check({tag, "_irq_vec"}, 32'(bus.irq_vec), 32'd0);
        check({tag, "_pending"}, 32'(pending), 32'd0);
        check({tag, "_mask"}, 32'(mask), 32'hFF);
        check({tag, "_ie"}, 32'(ie), 32'd1);
        check({tag, "_in_service"}, 32'(in_service), 32'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic       req_prev = 1'b0;
    logic [7:0] vec_hold = 8'h00;

    initial begin
        forever begin
            @(negedge clock);
            if (rst !== 1'b1) begin
                req_prev = 1'b0;
            end else begin
                if (bus.irq_req === 1'b1 && !req_prev) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_req: vec 0x%0h with no request expected", bus.irq_vec);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (bus.irq_vec !== e) begin
                            n_fail++;
                            $display("FAIL irq_vec: got 0x%0h, expected 0x%0h", bus.irq_vec, e);
                        end
                    end
                    vec_hold = bus.irq_vec;
                end else if (bus.irq_req === 1'b1) begin
                    n_checks++;
                    if (bus.irq_vec !== vec_hold) begin
                        n_fail++;
                        $display("FAIL vec_stable: got 0x%0h, expected 0x%0h", bus.irq_vec, vec_hold);
                    end
                end
                req_prev = bus.irq_req;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        bus.irq_ack    = 1'b0;
        bus.eoi        = 1'b0;
        bus.ei         = 1'b0;
        bus.di         = 1'b0;
        bus.mask_we    = 1'b0;
        bus.mask_wdata = 8'h00;

        // Reset with all sources held high.
        src = 8'hFF;
        tick(3);
        check_reset_vals("rst_hold");
        rst = 1'b1;
        m_pend = 8'hFF;
        expect_next();
        tick(2);
        check("rst_pend_early", 32'(pending), 32'h00);
        tick(1);
        check("rst_pend_3clk", 32'(pending), 32'hFF);
        src = 8'h00;
        tick(1);
        check("rst_req_4clk", 32'(bus.irq_req), 32'd1);
        drain();

        // Ack outside REQ is ignored.
        bus.irq_ack = 1'b1;
        tick(1);
        bus.irq_ack = 1'b0;
        check("stray_ack_ie", 32'(ie), 32'd1);
        check("stray_ack_in_service", 32'(in_service), 32'd0);

        // Single source held high: one event only.
        exp_q.push_back(vec_of(3));
        src = 8'h08;
        m_pend = 8'h08;
        tick(2);
        check("single_pend_early", 32'(pending), 32'h00);
        tick(1);
        check("single_pend", 32'(pending), 32'h08);
        check("single_req_early", 32'(bus.irq_req), 32'd0);
        tick(1);
        check("single_req", 32'(bus.irq_req), 32'd1);
        drain();
        tick(6);
        check("level_pend", 32'(pending), 32'h00);
        check("level_req", 32'(bus.irq_req), 32'd0);
        src = 8'h00;
        tick(4);

        // Priority: 6 before 1.
        raise(8'h42);
        expect_next();
        drain();

        // Masked source latches but does not request.
        write_mask(8'hBF);
        raise(8'h40);
        tick(6);
        check("mask_pend", 32'(pending), 32'h40);
        check("mask_req", 32'(bus.irq_req), 32'd0);
        m_mask = 8'hFF;
        expect_next();
        write_mask(8'hFF);
        check("unmask_req_early", 32'(bus.irq_req), 32'd0);
        tick(1);
        check("unmask_req", 32'(bus.irq_req), 32'd1);
        drain();

        // Withdraw by di; stray eoi ignored; ei re-requests.
        raise(8'h40);
        expect_next();
        wait_req(ok);
        bus.di = 1'b1;
        tick(1);
        bus.di = 1'b0;
        check("wd_req", 32'(bus.irq_req), 32'd0);
        check("wd_ie", 32'(ie), 32'd0);
        check("wd_pend", 32'(pending), 32'h40);
        bus.eoi = 1'b1;
        tick(1);
        bus.eoi = 1'b0;
        check("stray_eoi_ie", 32'(ie), 32'd0);
        expect_next();
        bus.ei = 1'b1;
        tick(1);
        bus.ei = 1'b0;
        check("ei_req_early", 32'(bus.irq_req), 32'd0);
        tick(1);
        check("ei_req", 32'(bus.irq_req), 32'd1);
        drain();

        // Masking the latched source in REQ withdraws.
        raise(8'h10);
        expect_next();
        wait_req(ok);
        write_mask(8'hEF);
        tick(1);
        check("mwd_req", 32'(bus.irq_req), 32'd0);
        check("mwd_pend", 32'(pending), 32'h10);
        m_mask = 8'hFF;
        expect_next();
        write_mask(8'hFF);
        tick(1);
        check("mwd_rereq", 32'(bus.irq_req), 32'd1);
        drain();

        // New edge on src[2] landing in its own ack cycle.
        raise(8'h04);
        expect_next();
        wait_req(ok);
        src = 8'h04;
        tick(2);
        bus.irq_ack = 1'b1;
        tick(1);
        bus.irq_ack = 1'b0;
        src = 8'h00;
        check("setwin_pend", 32'(pending), 32'h04);
        check("setwin_in_service", 32'(in_service), 32'd1);
        expect_next();
        bus.eoi = 1'b1;
        tick(1);
        bus.eoi = 1'b0;
        tick(1);
        check("setwin_rereq", 32'(bus.irq_req), 32'd1);
        drain();

        // Randomised traffic.
        for (int it = 0; it < 25; it++) begin
            logic [7:0] nm;
            logic [7:0] pat;
            nm  = 8'($urandom);
            pat = 8'($urandom_range(1, 255));
            if ((m_pend & nm) != 8'h00) exp_q.push_back(vec_of(top_idx(m_pend & nm)));
            write_mask(nm);
            drain();
            raise(pat);
            if ((m_pend & m_mask) != 8'h00) expect_next();
            tick(6);
            check("rnd_pend", 32'(pending), 32'(m_pend));
            drain();
            tick(2);
            check("rnd_idle_req", 32'(bus.irq_req), 32'd0);
            check("rnd_idle_pend", 32'(pending), 32'(m_pend));
        end
        if ((m_pend & 8'hFF) != 8'h00) exp_q.push_back(vec_of(top_idx(m_pend)));
        write_mask(8'hFF);
        drain();
        tick(4);

        // Asynchronous reset during SERVICE.
        write_mask(8'h7F);
        raise(8'h01);
        expect_next();
        wait_req(ok);
        bus.irq_ack = 1'b1;
        tick(1);
        bus.irq_ack = 1'b0;
        m_pend = 8'h00;
        raise(8'h20);
        tick(4);
        check("svc_pend", 32'(pending), 32'h20);
        check("svc_in_service", 32'(in_service), 32'd1);
        check("svc_req", 32'(bus.irq_req), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(negedge clock);
        rst = 1'b1;
        m_pend = 8'h00;
        m_mask = 8'hFF;
        tick(4);
        check("post_rst_req", 32'(bus.irq_req), 32'd0);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL exp_queue: %0d expected requests never seen, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Interrupt controller for the 8-bit button-driven CPU; replaces the CPU's ad hoc button-to-PC forcing.
- Synchronises and edge-detects up to 8 sources (buttons A/B, direction pad, timer tick) and holds them as pending bits under a CPU-written mask.
- Picks the highest-priority unmasked pending source and delivers one vector to the CPU fetch unit via a req/ack handshake.
- Blocks further requests until the CPU signals end-of-interrupt. No nesting.

Parameters:
- N_SRC, 8, number of interrupt sources (1..8).
- VBASE, 8'd2, vector address of source 0.
- VSTRIDE, 8'd2, vector spacing in RAM bytes (one JMP slot).
- MASK_RST, 8'hFF, mask value after reset (1 = enabled).

Ports:
- clock  in  1  system clock (CPU step clock).
- rst  in  1  reset, asynchronous, active-low.
- src  in  N_SRC  raw asynchronous interrupt sources, active-high.
- mask_we  in  1  write strobe for mask register.
- mask_wdata  in  8  new mask value (bits >= N_SRC ignored).
- ei  in  1  one-cycle pulse: enable interrupts (EI opcode).
- di  in  1  one-cycle pulse: disable interrupts (DI opcode).
- irq_ack  in  1  CPU accepts vector; must only be asserted while irq_req = 1.
- eoi  in  1  one-cycle pulse: end of service routine.
- irq_req  out  1  request to CPU, registered.
- irq_vec  out  8  vector address, registered; valid while irq_req = 1.
- pending  out  N_SRC  pending register.
- mask  out  8  current mask.
- ie  out  1  global interrupt enable.
- in_service  out  1  handler active.

Behaviour:
- Reset values: irq_req 0, irq_vec 0, pending 0, mask MASK_RST, ie 1, in_service 0, state IDLE, synchroniser and edge-history flops 0.
- Reset mid-operation aborts any REQ or SERVICE immediately.
- Synchroniser: two flops per source, then a history flop.
  - A rising edge of the synchronised source sets its pending bit.
  - Source high at cycle t gives its pending bit = 1 after clock edge t+3.
  - Levels are ignored; a source held high produces exactly one pending event.
- Pending clear: only by irq_ack, and only for the granted index.
- Same-cycle set and clear of the same bit: set wins, so the new edge is retained.
- Mask affects only arbitration; masked sources still latch pending.
- mask_we takes effect at the next edge and is legal in any state.
- Priority: highest index wins (src[N_SRC-1] is highest). Pure combinational encode over pending & mask.
- Vector: irq_vec = VBASE + idx*VSTRIDE, 8-bit modulo-256 arithmetic.
- ie: set by ei, cleared by di; if both arrive in the same cycle, di wins. Cleared automatically on irq_ack; set on eoi.
- FSM states:
  - IDLE: if ie && |(pending & mask) → REQ. Latch idx and irq_vec; irq_req = 1 from the next edge. Request appears 1 clock after pending becomes visible.
  - REQ: irq_req and irq_vec held stable. No re-arbitration, even if a higher-priority source arrives.
    - irq_ack → clear pending[idx], irq_req = 0, ie = 0, in_service = 1 → SERVICE.
    - di (without ack) → withdraw: irq_req = 0, pending unchanged → IDLE.
    - Masking the latched source while in REQ also withdraws → IDLE.
    - If ack and di arrive in the same cycle, ack wins.
  - SERVICE: pending continues to accumulate. ei/di update ie but no request is raised.
    - eoi → in_service = 0, ie = 1 → IDLE.
    - irq_ack in SERVICE is ignored.
- eoi outside SERVICE is ignored.
- irq_ack outside REQ is ignored (verification flags it as a protocol error).
- Back-to-back: eoi at edge e with another source pending gives irq_req = 1 after edge e+1.

Decomposition:
- Package irq_pkg: state enum (IDLE, REQ, SERVICE); constants IRQ_W = 8 and VEC_W = 8; default VBASE and VSTRIDE.
- One sub-module, irq_prio_enc: combinational N_SRC-bit priority encoder producing idx[2:0] and any.
- Synchroniser, edge detect and FSM stay in irq_sequencer.

Test Plan:
- Reset: hold rst = 0 with src = 8'hFF → irq_req 0, irq_vec 0, pending 0, mask FF, ie 1, in_service 0. Release → pending 8'hFF after 3 clocks, irq_req with vec 16.
- Single source: src[3] rises → pending = 8'h08 at +3, irq_req = 1 with vec 8 at +4. Ack → pending 0, ie 0, in_service 1. eoi → ie 1, in_service 0, IDLE.
- Priority: src[1] and src[6] rise together → vec 14 first. Ack, eoi → next request vec 4 one clock after eoi.
- Mask: mask = 8'hBF, src[6] rises → pending bit 6 set, irq_req stays 0. Write mask FF → irq_req with vec 14 two clocks later.
- Withdraw: di pulse in REQ before ack → irq_req 0 next clock, pending 8'h40 kept. ei → irq_req again with vec 14.
- Corner cases:
  - src[2] re-rises with its synchronised edge landing in the ack cycle of src[2] → pending[2] stays 1.
  - rst pulse during SERVICE → all outputs return to reset values asynchronously.
